// File: rtl/hpu_pkg.sv
// Shared sprite/tile pixel types and the fetch-FSM state encoding.
package hpu_pkg;
    localparam int PIX_W    = 3;
    localparam int SPR_PIX  = 8;
    localparam int SPR_ROWS = 8;

    typedef logic [PIX_W-1:0]   pixel_t;
    typedef pixel_t [SPR_PIX-1:0] row_t;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_CHECK,
        FS_REQ,
        FS_WAIT,
        FS_DONE
    } fetch_state_t;
endpackage

// File: rtl/hpu_sprite_row_unpack.sv
// Unpacks one 24-bit pattern row into eight pixels, optionally mirrored.
// Latency: combinational. Backpressure: none.
module hpu_sprite_row_unpack
    import hpu_pkg::*;
(
    input  logic [PIX_W*SPR_PIX-1:0] data_i,
    input  logic                     hflip_i,
    output row_t                     row_o
);

    always_comb begin
        row_o = '0;
        for (int i = 0; i < SPR_PIX; i++) begin
            if (hflip_i) begin
                row_o[i] = data_i[PIX_W*(SPR_PIX-1-i) +: PIX_W];
            end else begin
                row_o[i] = data_i[PIX_W*i +: PIX_W];
            end
        end
    end

endmodule

// File: rtl/hpu_sprite_fetch.sv
// Sprite row fetcher: checks next-line coverage in hblank, reads one pattern row into a shadow buffer, commits it on swap.
// Latency: out-of-range done 2 cycles after fetch_start; in-range done RD_LATENCY+1 cycles after the accepted grant.
// Backpressure: mem_req/mem_addr held until grant; swap or fetch_start while busy aborts the fetch and pulses overrun.
module hpu_sprite_fetch
    import hpu_pkg::*;
#(
    parameter int TILE_W     = 6,
    parameter int RD_LATENCY = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     fetch_start_i,
    input  logic [9:0]               fetch_line_i,
    input  logic                     swap_i,
    input  logic [7:0]               attr_x_i,
    input  logic [7:0]               attr_y_i,
    input  logic [TILE_W-1:0]        attr_tile_i,
    input  logic                     attr_hflip_i,
    output logic                     mem_req_o,
    output logic [TILE_W+2:0]        mem_addr_o,
    input  logic                     mem_grant_i,
    input  logic [PIX_W*SPR_PIX-1:0] mem_rdata_i,
    output row_t                     line_buf_o,
    output logic [7:0]               sprite_x_o,
    output logic [7:0]               sprite_y_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overrun_o
);

    localparam logic [2:0] RD_LAT_C = 3'(RD_LATENCY);

    fetch_state_t      state_q;
    logic [9:0]        line_q;
    logic [7:0]        att_x_q;
    logic [7:0]        att_y_q;
    logic [TILE_W-1:0] att_tile_q;
    logic              att_hflip_q;
    logic [2:0]        lat_cnt_q;
    row_t              shadow_q;
    logic              shadow_rdy_q;
    logic              mem_req_q;
    logic [TILE_W+2:0] mem_addr_q;
    row_t              line_buf_q;
    logic [7:0]        sprite_x_q;
    logic [7:0]        sprite_y_q;
    logic              busy_q;
    logic              done_q;
    logic              overrun_q;

    logic [9:0] y_ext;
    logic       in_range;
    logic [2:0] row;
    row_t       rd_row;

    assign y_ext    = {2'b00, att_y_q};
    assign in_range = (line_q >= y_ext) && (line_q < y_ext + 10'd8);
    // Only the low three bits of (line - y) matter once the line is in range.
    assign row      = line_q[2:0] - att_y_q[2:0];

    hpu_sprite_row_unpack u_unpack (
        .data_i  (mem_rdata_i),
        .hflip_i (att_hflip_q),
        .row_o   (rd_row)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= FS_IDLE;
            line_q       <= '0;
            att_x_q      <= '0;
            att_y_q      <= '0;
            att_tile_q   <= '0;
            att_hflip_q  <= 1'b0;
            lat_cnt_q    <= '0;
            shadow_q     <= '0;
            shadow_rdy_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            line_buf_q   <= '0;
            sprite_x_q   <= '0;
            sprite_y_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            overrun_q <= 1'b0;

            // Swap is judged against the state before any same-cycle restart.
            if (swap_i) begin
                if (state_q == FS_IDLE) begin
                    if (shadow_rdy_q) begin
                        line_buf_q   <= shadow_q;
                        sprite_x_q   <= att_x_q;
                        sprite_y_q   <= att_y_q;
                        shadow_rdy_q <= 1'b0;
                    end else begin
                        line_buf_q <= '0;
                    end
                end else begin
                    line_buf_q   <= '0;
                    overrun_q    <= 1'b1;
                    shadow_rdy_q <= 1'b0;
                    mem_req_q    <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= FS_IDLE;
                end
            end

            if (fetch_start_i) begin
                if (state_q != FS_IDLE) begin
                    overrun_q <= 1'b1;
                end
                line_q       <= fetch_line_i;
                att_x_q      <= attr_x_i;
                att_y_q      <= attr_y_i;
                att_tile_q   <= attr_tile_i;
                att_hflip_q  <= attr_hflip_i;
                shadow_rdy_q <= 1'b0;
                mem_req_q    <= 1'b0;
                busy_q       <= 1'b1;
                state_q      <= FS_CHECK;
            end else if (!(swap_i && state_q != FS_IDLE)) begin
                case (state_q)
                    FS_IDLE: ;
                    FS_CHECK: begin
                        if (in_range) begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {att_tile_q, row};
                            state_q    <= FS_REQ;
                        end else begin
                            shadow_q     <= '0;
                            shadow_rdy_q <= 1'b1;
                            done_q       <= 1'b1;
                            state_q      <= FS_DONE;
                        end
                    end
                    FS_REQ: begin
                        if (mem_grant_i) begin
                            mem_req_q <= 1'b0;
                            lat_cnt_q <= 3'd1;
                            state_q   <= FS_WAIT;
                        end
                    end
                    FS_WAIT: begin
                        if (lat_cnt_q == RD_LAT_C) begin
                            shadow_q     <= rd_row;
                            shadow_rdy_q <= 1'b1;
                            done_q       <= 1'b1;
                            state_q      <= FS_DONE;
                        end else begin
                            lat_cnt_q <= lat_cnt_q + 3'd1;
                        end
                    end
                    FS_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= FS_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= FS_IDLE;
                    end
                endcase
            end
        end
    end

    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign line_buf_o = line_buf_q;
    assign sprite_x_o = sprite_x_q;
    assign sprite_y_o = sprite_y_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_hpu_sprite_fetch.sv
// Self-checking bench for hpu_sprite_fetch: directed vector table, corner sequences and a randomized run against a row model.
module tb_hpu_sprite_fetch;
    import hpu_pkg::*;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_start;
    logic [9:0]  fetch_line;
    logic        swap;
    logic [7:0]  attr_x;
    logic [7:0]  attr_y;
    logic [5:0]  attr_tile;
    logic        attr_hflip;
    logic        mem_req;
    logic [8:0]  mem_addr;
    logic        mem_grant;
    logic [23:0] mem_rdata;
    row_t        line_buf;
    logic [7:0]  sprite_x;
    logic [7:0]  sprite_y;
    logic        busy;
    logic        done;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hpu_sprite_fetch #(.TILE_W(6), .RD_LATENCY(LAT)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .fetch_start_i (fetch_start),
        .fetch_line_i  (fetch_line),
        .swap_i        (swap),
        .attr_x_i      (attr_x),
        .attr_y_i      (attr_y),
        .attr_tile_i   (attr_tile),
        .attr_hflip_i  (attr_hflip),
        .mem_req_o     (mem_req),
        .mem_addr_o    (mem_addr),
        .mem_grant_i   (mem_grant),
        .mem_rdata_i   (mem_rdata),
        .line_buf_o    (line_buf),
        .sprite_x_o    (sprite_x),
        .sprite_y_o    (sprite_y),
        .busy_o        (busy),
        .done_o        (done),
        .overrun_o     (overrun)
    );

    typedef struct {
        logic [7:0]  y;
        logic [9:0]  ln;
        logic [5:0]  tile;
        logic        hf;
        logic [7:0]  x;
        logic [23:0] d;
        int          gd;
        logic        ef;
        logic [8:0]  ea;
        logic [23:0] eb;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Row the sprite should show on a line, straight from the coverage and mirroring rules.
    function automatic logic [23:0] model_row(input int y, input int ln, input logic hf, input logic [23:0] d);
        logic [23:0] r;
        r = '0;
        if (ln < y || ln >= y + 8) return r;
        for (int i = 0; i < 8; i++) begin
            int src;
            src = hf ? 7 - i : i;
            r[3*i +: 3] = d[3*src +: 3];
        end
        return r;
    endfunction

    task automatic start(input logic [7:0] y, input logic [9:0] ln, input logic [5:0] tile,
                         input logic hf, input logic [7:0] x);
        attr_y = y; fetch_line = ln; attr_tile = tile; attr_hflip = hf; attr_x = x;
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
    endtask

    task automatic do_fetch(input logic [7:0] y, input logic [9:0] ln, input logic [5:0] tile,
                            input logic hf, input logic [7:0] x, input logic [23:0] d,
                            input int gd, input logic ef, input logic [8:0] ea);
        @(negedge clk);
        start(y, ln, tile, hf, x);
        chk("check_busy", busy, 1);
        chk("check_noreq", mem_req, 0);
        @(negedge clk);
        if (!ef) begin
            chk("oor_done", done, 1);
            chk("oor_noreq", mem_req, 0);
        end else begin
            for (int k = 0; k <= gd; k++) begin
                chk("req_held", mem_req, 1);
                chk("addr_held", mem_addr, ea);
                mem_grant = (k == gd);
                @(negedge clk);
                mem_grant = 1'b0;
            end
            chk("req_drop", mem_req, 0);
            for (int k = 1; k <= LAT; k++) begin
                mem_rdata = (k == LAT) ? d : $urandom;
                chk("wait_nodone", done, 0);
                @(negedge clk);
            end
            mem_rdata = $urandom;
            chk("fetch_done", done, 1);
        end
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle", busy, 0);
    endtask

    task automatic swap_check(input logic [23:0] eb, input logic [7:0] ex, input logic [7:0] ey);
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        chk("swap_buf", line_buf, eb);
        chk("swap_x", sprite_x, ex);
        chk("swap_y", sprite_y, ey);
        chk("swap_noovr", overrun, 0);
    endtask

    initial begin
        vecs[0] = '{8'd20,  10'd10,  6'd3,  1'b0, 8'd1, 24'hFAC688, 0, 1'b0, 9'h000, 24'h000000};
        vecs[1] = '{8'd20,  10'd20,  6'd5,  1'b0, 8'd2, 24'hFAC688, 0, 1'b1, 9'h028, 24'hFAC688};
        vecs[2] = '{8'd20,  10'd27,  6'd5,  1'b1, 8'd3, 24'hFAC688, 5, 1'b1, 9'h02F, 24'h053977};
        vecs[3] = '{8'd20,  10'd28,  6'd5,  1'b1, 8'd4, 24'hFAC688, 0, 1'b0, 9'h000, 24'h000000};
        vecs[4] = '{8'd255, 10'd262, 6'd63, 1'b0, 8'd5, 24'h123456, 1, 1'b1, 9'h1FF, 24'h123456};
        vecs[5] = '{8'd255, 10'd263, 6'd63, 1'b0, 8'd6, 24'h123456, 0, 1'b0, 9'h000, 24'h000000};
        vecs[6] = '{8'd200, 10'd199, 6'd7,  1'b0, 8'd7, 24'h123456, 0, 1'b0, 9'h000, 24'h000000};
        vecs[7] = '{8'd0,   10'd0,   6'd0,  1'b1, 8'd8, 24'hFAC688, 2, 1'b1, 9'h000, 24'h053977};

        rst = 1'b1; fetch_start = 1'b0; swap = 1'b0; mem_grant = 1'b0; mem_rdata = '0;
        fetch_line = '0; attr_x = '0; attr_y = '0; attr_tile = '0; attr_hflip = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_buf", line_buf, 0);
        chk("rst_x", sprite_x, 0);
        chk("rst_y", sprite_y, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", overrun, 0);

        for (int v = 0; v < 8; v++) begin
            do_fetch(vecs[v].y, vecs[v].ln, vecs[v].tile, vecs[v].hf, vecs[v].x,
                     vecs[v].d, vecs[v].gd, vecs[v].ef, vecs[v].ea);
            swap_check(vecs[v].eb, vecs[v].x, vecs[v].y);
        end

        // Swap while waiting for a grant; the same-cycle and a later grant must not land.
        @(negedge clk);
        start(8'd40, 10'd42, 6'd9, 1'b0, 8'd99);
        @(negedge clk);
        chk("ovr_req", mem_req, 1);
        @(negedge clk);
        swap = 1'b1; mem_grant = 1'b1; mem_rdata = 24'hFAC688;
        @(negedge clk);
        swap = 1'b0; mem_grant = 1'b0;
        chk("ovr_pulse", overrun, 1);
        chk("ovr_buf", line_buf, 0);
        chk("ovr_reqdrop", mem_req, 0);
        chk("ovr_busy", busy, 0);
        mem_grant = 1'b1;
        @(negedge clk);
        mem_grant = 1'b0;
        chk("ovr_once", overrun, 0);
        repeat (LAT + 1) begin
            chk("ovr_nodone", done, 0);
            @(negedge clk);
        end
        swap_check(24'h0, 8'd8, 8'd0);

        // Restart while busy with an out-of-range sprite.
        @(negedge clk);
        start(8'd50, 10'd51, 6'd1, 1'b0, 8'd33);
        @(negedge clk);
        start(8'd100, 10'd10, 6'd2, 1'b0, 8'd77);
        chk("rst_ovr_pulse", overrun, 1);
        chk("rst_ovr_busy", busy, 1);
        chk("rst_ovr_req", mem_req, 0);
        @(negedge clk);
        chk("rst_ovr_done", done, 1);
        @(negedge clk);
        swap_check(24'h0, 8'd77, 8'd100);

        // Swap and fetch_start together: the finished row commits, then the new fetch runs.
        do_fetch(8'd30, 10'd33, 6'd2, 1'b0, 8'd44, 24'h123456, 0, 1'b1, {6'd2, 3'd3});
        attr_y = 8'd60; fetch_line = 10'd5; attr_x = 8'd11; attr_tile = 6'd0; attr_hflip = 1'b0;
        swap = 1'b1; fetch_start = 1'b1;
        @(negedge clk);
        swap = 1'b0; fetch_start = 1'b0;
        chk("both_buf", line_buf, 24'h123456);
        chk("both_y", sprite_y, 8'd30);
        chk("both_noovr", overrun, 0);
        chk("both_busy", busy, 1);
        @(negedge clk);
        chk("both_done", done, 1);
        @(negedge clk);
        swap_check(24'h0, 8'd11, 8'd60);

        // Reset in the middle of the read wait.
        do_fetch(8'd70, 10'd71, 6'd4, 1'b0, 8'd12, 24'hFAC688, 0, 1'b1, {6'd4, 3'd1});
        swap_check(24'hFAC688, 8'd12, 8'd70);
        @(negedge clk);
        start(8'd70, 10'd70, 6'd1, 1'b0, 8'd5);
        @(negedge clk);
        mem_grant = 1'b1;
        @(negedge clk);
        mem_grant = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_buf", line_buf, 0);
        chk("mid_rst_x", sprite_x, 0);
        chk("mid_rst_y", sprite_y, 0);
        chk("mid_rst_req", mem_req, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (LAT + 1) @(negedge clk);
        chk("mid_rst_nodone", done, 0);
        swap_check(24'h0, 8'd0, 8'd0);

        // Randomized fetches against the row model.
        for (int n = 0; n < 40; n++) begin
            logic [7:0]  ry;
            logic [9:0]  rl;
            logic [5:0]  rt;
            logic        rh;
            logic [7:0]  rx;
            logic [23:0] rd;
            logic        inr;
            int          off;
            ry  = 8'($urandom);
            off = int'($urandom_range(0, 12)) - 2;
            rl  = 10'((int'(ry) + off + 1024) % 1024);
            rt  = 6'($urandom);
            rh  = 1'($urandom);
            rx  = 8'($urandom);
            rd  = 24'($urandom);
            inr = (off >= 0) && (off < 8);
            do_fetch(ry, rl, rt, rh, rx, rd, int'($urandom_range(0, 3)), inr, {rt, 3'(off)});
            swap_check(model_row(int'(ry), int'(rl), rh, rd), rx, ry);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hpu_sprite_fetch.md
Name: hpu_sprite_fetch

Overview:
- Upstream stage of the per-sprite pixel mux (hpu_sprite). It fills that block's 8-entry, 3-bit line buffer and the sprite_x/sprite_y values it compares against.
- During horizontal blanking it checks whether the sprite covers the next displayed line. If it does, it fetches that sprite row (8 pixels x 3 bits) from pattern memory over a req/grant port into a shadow buffer.
- The shadow buffer is committed to the visible outputs on the line-start swap pulse. This double-buffering keeps the displayed line stable while the next one is fetched.

Parameters:
- TILE_W, 6, width of sprite tile index; pattern address width is TILE_W+3.
- RD_LATENCY, 1, cycles from the sampled mem_grant to valid mem_rdata (legal range 1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- fetch_start  in  1  one-cycle pulse at hblank start; samples all attribute inputs.
- fetch_line  in  10  line number that will be displayed next.
- swap  in  1  one-cycle pulse at start of the displayed line; commits shadow to outputs.
- attr_x  in  8  sprite X position.
- attr_y  in  8  sprite Y position.
- attr_tile  in  TILE_W  tile index.
- attr_hflip  in  1  horizontal mirror.
- mem_req  out  1  pattern read request.
- mem_addr  out  TILE_W+3  {tile, row[2:0]}.
- mem_grant  in  1  arbiter accepts the request this cycle.
- mem_rdata  in  24  row data; pixel i = bits [3i+2:3i].
- line_buf  out  3 x [7:0]  visible row; feeds hpu_sprite.line_buf.
- sprite_x  out  8  visible X; feeds hpu_sprite.sprite_x.
- sprite_y  out  8  visible Y; feeds hpu_sprite.sprite_y.
- busy  out  1  fetch in progress (state != IDLE).
- done  out  1  one-cycle pulse when the shadow buffer is ready.
- overrun  out  1  one-cycle pulse on swap-while-busy or restart-while-busy.

Behaviour:
- Reset: line_buf all 0, sprite_x=0, sprite_y=0, mem_req=0, mem_addr=0, busy=0, done=0, overrun=0. Shadow buffer cleared and shadow_ready=0. State=IDLE. Reset mid-fetch abandons the request immediately (mem_req low the next cycle).
- FSM states: IDLE, CHECK, REQ, WAIT, DONE.
- IDLE -> CHECK on fetch_start. The attributes and fetch_line are registered in this transition.
- CHECK, one cycle: in-range means fetch_line >= {2'b0,attr_y} and fetch_line < {2'b0,attr_y}+8, computed at 10 bits (max 263, no overflow). row = (fetch_line - attr_y)[2:0].
  - In range: go to REQ.
  - Not in range: shadow pixels = 0 (transparent), go to DONE. No memory access.
- REQ: mem_req=1; mem_addr = {tile,row} held stable until mem_grant is sampled high. Then mem_req drops the next cycle; go to WAIT.
- WAIT: counts RD_LATENCY cycles after grant and captures mem_rdata in the final cycle.
  - hflip=0: shadow[i] = pixel i.
  - hflip=1: shadow[i] = pixel 7-i.
  - Then go to DONE.
- DONE: done=1 for one cycle, shadow_ready=1, go to IDLE.
- Latency, out-of-range: fetch_start at cycle 0 -> done at cycle 2.
- Latency, in range with immediate grant and RD_LATENCY=1: fetch_start at cycle 0, mem_req at cycle 2, grant at cycle 2, capture at cycle 3, done at cycle 4.
- swap while IDLE and shadow_ready=1: line_buf, sprite_x and sprite_y load the shadow values the next cycle; shadow_ready clears.
- swap while IDLE and shadow_ready=0: line_buf loads all 0 (sprite hidden); sprite_x/y unchanged.
- swap while busy: line_buf loads all 0 and overrun pulses. The fetch aborts to IDLE, mem_req drops the next cycle and shadow_ready=0. A grant in that same cycle is ignored and its data discarded.
- fetch_start while busy: overrun pulses and the FSM restarts in CHECK with the new attributes; any pending read is discarded.
- swap and fetch_start in the same cycle: swap is evaluated first against the old state, then the new fetch starts.
- Outputs are registered; line_buf is stable across the whole displayed line.

Decomposition:
- Shared package hpu_pkg holds:
  - PIX_W=3, SPR_PIX=8, SPR_ROWS=8;
  - the pixel_t (logic [2:0]) typedef and the row_t (pixel_t [7:0]) typedef;
  - the fetch-FSM state enum.
- One combinational sub-module, hpu_sprite_row_unpack: converts 24-bit data plus hflip into row_t. It is reused by future background-tile fetchers.

Test Plan:
- Out-of-range: attr_y=20, fetch_line=10, fetch_start then swap -> no mem_req, done 2 cycles after start, line_buf all 0, sprite_y=20.
- Top boundary, no flip: attr_y=20, fetch_line=20, tile=5, immediate grant -> mem_addr=9'h028, rdata=24'hFAC688. After swap, line_buf[0..7]=0,1,2,3,4,5,6,7.
- Bottom boundary, hflip=1: fetch_line=27, attr_y=20, same rdata -> mem_addr row=7, line_buf[0..7]=7,6,5,4,3,2,1,0. With fetch_line=28 -> no fetch, all 0.
- Delayed grant: grant held low 5 cycles, RD_LATENCY=2 -> mem_req and mem_addr stable for all 6 cycles. Data is captured 2 cycles after the grant and done follows 1 cycle later.
- Overrun: swap asserted while in REQ -> overrun pulse, line_buf all 0, mem_req low the next cycle. A late grant does not alter the shadow buffer; the next swap gives all 0.
- Reset mid-WAIT: rst high 1 cycle -> all outputs at reset values the next cycle, busy=0, mem_req=0.
